// File: rtl/l1c_mem_responder_if.sv
// Cache-side and memory-side buses of the L1 cache-to-memory responder.
// Latency: n/a (signal bundles only).
// Backpressure: cwait on the cache bus, mem_gnt on the memory bus.
//
// l1c_cache_if: creq/caddr/cwrite/cin/ctype from the cache, cout/cwait back.
// l1c_mem_if  : mem_req/we/addr/wdata/wstrb to memory, mem_gnt/rvalid/rdata back.

interface l1c_cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              creq;
    logic [ADDR_W-1:0] caddr;
    logic              cwrite;
    logic [DATA_W-1:0] cin;
    logic [2:0]        ctype;
    logic [DATA_W-1:0] cout;
    logic              cwait;

    modport master (output creq, caddr, cwrite, cin, ctype, input cout, cwait);
    modport slave  (input creq, caddr, cwrite, cin, ctype, output cout, cwait);
endinterface

interface l1c_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
                    output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/l1c_mem_responder.sv
// Memory-side responder: 4-word line refills (up to 4 reads in flight, delivered in
// order) and byte-masked write-through stores onto a pipelined req/gnt word memory.
// Latency: refill word0 earliest 3 cycles after creq; store acked the cycle after gnt.
// Backpressure: cwait holds the cache; mem_gnt stalls issue; returns are buffered.
//
// Ports: clk, rst (async, active-high); cache = l1c_cache_if.slave; mem = l1c_mem_if.master.

module l1c_mem_responder #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic        clk,
    input  logic        rst,
    l1c_cache_if.slave  cache,
    l1c_mem_if.master   mem
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RD     = 2'd1;
    localparam logic [1:0] S_WR     = 2'd2;
    localparam logic [1:0] S_WR_ACK = 2'd3;

    localparam logic [2:0] CT_BYTE    = 3'd0;
    localparam logic [2:0] CT_HWORD   = 3'd1;
    localparam logic [2:0] CT_WORD    = 3'd2;
    localparam logic [2:0] CT_BYTE_U  = 3'd3;
    localparam logic [2:0] CT_HWORD_U = 3'd4;

    localparam logic [2:0] LINE_CNT  = 3'(LINE_WORDS);
    localparam logic [1:0] LAST_WORD = 2'(LINE_WORDS - 1);

    logic [1:0]        state;
    logic [ADDR_W-1:0] base;
    logic [2:0]        iss_cnt;
    logic [2:0]        ret_cnt;
    logic [1:0]        dlv_cnt;
    logic [3:0]        vld;
    logic [3:0]        vld_next;
    logic [DATA_W-1:0] line_buf [0:3];
    logic              abort;

    logic              rd_active;
    logic              aborting;
    logic              issuing;
    logic              ret_fire;
    logic              deliver;
    logic [2:0]        outstanding;
    logic              drain_done;
    logic [3:0]        st_strb;
    logic [DATA_W-1:0] st_data;

    // Once creq drops in RD the refill is dead for good, even if creq rises again
    // before the outstanding reads have drained.
    assign rd_active   = (state == S_RD);
    assign aborting    = rd_active & (abort | ~cache.creq);
    assign issuing     = rd_active & ~aborting & (iss_cnt != LINE_CNT);
    assign outstanding = iss_cnt - ret_cnt;
    // Returns are only accepted against reads we actually issued.
    assign ret_fire    = rd_active & mem.mem_rvalid & (outstanding != 3'd0);
    assign deliver     = rd_active & ~aborting & vld[dlv_cnt];
    assign drain_done  = aborting & ((outstanding == 3'd0) ||
                                     ((outstanding == 3'd1) && ret_fire));

    // Clear before set: the return slot and the delivery slot never coincide
    // within one line, so the order only matters for readability.
    always_comb begin
        vld_next = vld;
        if (deliver)  vld_next[dlv_cnt] = 1'b0;
        if (ret_fire) vld_next[ret_cnt[1:0]] = 1'b1;
    end

    always_comb begin
        st_strb = 4'h0;
        st_data = cache.cin;
        case (cache.ctype)
            CT_BYTE, CT_BYTE_U: begin
                st_strb = 4'b0001 << cache.caddr[1:0];
                st_data = {4{cache.cin[7:0]}};
            end
            CT_HWORD, CT_HWORD_U: begin
                st_strb = 4'b0011 << {cache.caddr[1], 1'b0};
                st_data = {2{cache.cin[15:0]}};
            end
            CT_WORD: begin
                st_strb = 4'hF;
                st_data = cache.cin;
            end
            default: begin
                st_strb = 4'h0;
                st_data = cache.cin;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            base    <= '0;
            iss_cnt <= '0;
            ret_cnt <= '0;
            dlv_cnt <= '0;
            vld     <= '0;
            abort   <= 1'b0;
            for (int i = 0; i < 4; i++) line_buf[i] <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    iss_cnt <= '0;
                    ret_cnt <= '0;
                    dlv_cnt <= '0;
                    vld     <= '0;
                    abort   <= 1'b0;
                    if (cache.creq) begin
                        state <= cache.cwrite ? S_WR : S_RD;
                        base  <= {cache.caddr[ADDR_W-1:4], 4'b0000};
                    end
                end
                S_RD: begin
                    if (issuing && mem.mem_gnt) iss_cnt <= iss_cnt + 3'd1;
                    if (ret_fire) begin
                        line_buf[ret_cnt[1:0]] <= mem.mem_rdata;
                        ret_cnt                <= ret_cnt + 3'd1;
                    end
                    vld <= vld_next;
                    if (deliver) dlv_cnt <= dlv_cnt + 2'd1;
                    if (!cache.creq) abort <= 1'b1;
                    if ((deliver && (dlv_cnt == LAST_WORD)) || drain_done)
                        state <= S_IDLE;
                end
                S_WR: begin
                    if (mem.mem_gnt) state <= S_WR_ACK;
                end
                S_WR_ACK: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is high so the reset is visible in the
    // same cycle it is asserted, even though creq may still be held.
    always_comb begin
        cache.cout     = '0;
        cache.cwait    = 1'b0;
        mem.mem_req    = 1'b0;
        mem.mem_we     = 1'b0;
        mem.mem_addr   = '0;
        mem.mem_wdata  = '0;
        mem.mem_wstrb  = 4'h0;
        case (state)
            S_IDLE: cache.cwait = cache.creq;
            S_RD: begin
                cache.cwait = ~aborting & ~deliver;
                if (deliver) cache.cout = line_buf[dlv_cnt];
                mem.mem_req = issuing;
                if (issuing) mem.mem_addr = {base[ADDR_W-1:4], iss_cnt[1:0], 2'b00};
            end
            S_WR: begin
                cache.cwait   = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = {cache.caddr[ADDR_W-1:2], 2'b00};
                mem.mem_wdata = st_data;
                mem.mem_wstrb = st_strb;
            end
            default: cache.cwait = 1'b0;
        endcase
        if (rst) begin
            cache.cout    = '0;
            cache.cwait   = 1'b0;
            mem.mem_req   = 1'b0;
            mem.mem_we    = 1'b0;
            mem.mem_addr  = '0;
            mem.mem_wdata = '0;
            mem.mem_wstrb = 4'h0;
        end
    end
endmodule

// File: tb/tb_l1c_mem_responder.sv
module tb_l1c_mem_responder;
    localparam logic [2:0] CT_BYTE    = 3'd0;
    localparam logic [2:0] CT_WORD    = 3'd2;
    localparam logic [2:0] CT_HWORD_U = 3'd4;
    localparam logic [2:0] CT_BAD     = 3'd7;

    typedef struct { logic [31:0] dat; int cyc; } rd_exp_t;
    typedef struct { logic [31:0] addr; logic [31:0] dat; logic [3:0] strb; } wr_exp_t;
    typedef struct { logic [31:0] addr; int due; } pend_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1c_cache_if cif ();
    l1c_mem_if   mif ();

    l1c_mem_responder dut (
        .clk   (clk),
        .rst   (rst),
        .cache (cif.slave),
        .mem   (mif.master)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int gnt_stall = 0;
    int rlat = 1;
    int stall_cnt = 0;
    int rd_grants = 0;
    int dlv_seen = 0;
    int acks_seen = 0;
    int wr_gnt_cyc = -10;
    int stray_req = 0;
    int stray_done = 0;

    rd_exp_t     exp_rd [$];
    logic [31:0] exp_ra [$];
    wr_exp_t     exp_wr [$];
    pend_t       pend   [$];

    always @(posedge clk) cyc++;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor (cache side, sampled mid-cycle) followed by the memory model,
    // which also checks every granted memory request against the scoreboard.
    always @(negedge clk) begin
        if (!rst && cif.creq && !cif.cwrite && !cif.cwait) begin
            if (exp_rd.size() == 0) begin
                chk("unexpected_refill_word", cif.cout, 32'hxxxx_xxxx);
            end else begin
                rd_exp_t e;
                e = exp_rd.pop_front();
                chk("refill_word", cif.cout, e.dat);
                if (e.cyc >= 0) chk("refill_word_cycle", cyc, e.cyc);
            end
            dlv_seen++;
        end
        if (!rst && cif.creq && cif.cwrite && !cif.cwait) begin
            chk("store_ack_cycle", cyc, wr_gnt_cyc + 1);
            acks_seen++;
        end
        if (!rst && !cif.creq) begin
            chk("cwait_without_creq", {31'b0, cif.cwait}, 32'd0);
            chk("mem_req_without_creq", {31'b0, mif.mem_req}, 32'd0);
        end

        #2;
        if (rst) begin
            pend.delete();
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = '0;
            stall_cnt      = 0;
        end else begin
            mif.mem_gnt = 1'b0;
            if (mif.mem_req) begin
                if (stall_cnt >= gnt_stall) begin
                    mif.mem_gnt = 1'b1;
                    stall_cnt   = 0;
                    if (mif.mem_we) begin
                        wr_gnt_cyc = cyc;
                        if (exp_wr.size() == 0) begin
                            chk("unexpected_write", mif.mem_addr, 32'hxxxx_xxxx);
                        end else begin
                            wr_exp_t w;
                            w = exp_wr.pop_front();
                            chk("write_addr", mif.mem_addr, w.addr);
                            chk("write_strb", {28'b0, mif.mem_wstrb}, {28'b0, w.strb});
                            if (w.strb != 4'h0) chk("write_data", mif.mem_wdata, w.dat);
                        end
                    end else begin
                        rd_grants++;
                        if (exp_ra.size() == 0) chk("unexpected_read", mif.mem_addr, 32'hxxxx_xxxx);
                        else chk("read_addr", mif.mem_addr, exp_ra.pop_front());
                        pend.push_back('{addr: mif.mem_addr, due: cyc + rlat});
                    end
                end else begin
                    stall_cnt++;
                end
            end else begin
                stall_cnt = 0;
            end
            mif.mem_rvalid = 1'b0;
            mif.mem_rdata  = '0;
            if (stray_req != stray_done) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = 32'hBAD0_BAD0;
                stray_done++;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                mif.mem_rvalid = 1'b1;
                mif.mem_rdata  = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_cout"},      cif.cout, 32'd0);
        chk({tag, "_cwait"},     {31'b0, cif.cwait}, 32'd0);
        chk({tag, "_mem_req"},   {31'b0, mif.mem_req}, 32'd0);
        chk({tag, "_mem_we"},    {31'b0, mif.mem_we}, 32'd0);
        chk({tag, "_mem_addr"},  mif.mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mif.mem_wdata, 32'd0);
        chk({tag, "_mem_wstrb"}, {28'b0, mif.mem_wstrb}, 32'd0);
    endtask

    task automatic wait_count(input string nm, ref int cnt, input int target);
        int n = 0;
        while (cnt < target && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk(nm, cnt, target);
    endtask

    task automatic refill(input logic [31:0] caddr, input logic [31:0] exp_base,
                          input int gs, input int rl, input bit timed);
        int c0;
        int target;
        gnt_stall = gs;
        rlat      = rl;
        @(posedge clk); #1;
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            exp_ra.push_back(exp_base + 32'(4 * i));
            exp_rd.push_back('{dat: mem_word(exp_base + 32'(4 * i)), cyc: timed ? c0 + 3 + i : -1});
        end
        cif.caddr  = caddr;
        cif.cwrite = 1'b0;
        cif.creq   = 1'b1;
        target = dlv_seen + 4;
        wait_count("refill_complete", dlv_seen, target);
        #1 cif.creq = 1'b0;
    endtask

    task automatic store(input logic [31:0] caddr, input logic [31:0] din, input logic [2:0] ct,
                         input logic [31:0] e_addr, input logic [31:0] e_dat, input logic [3:0] e_strb);
        int target;
        gnt_stall = 1;
        exp_wr.push_back('{addr: e_addr, dat: e_dat, strb: e_strb});
        @(posedge clk); #1;
        cif.caddr  = caddr;
        cif.cin    = din;
        cif.ctype  = ct;
        cif.cwrite = 1'b1;
        cif.creq   = 1'b1;
        target = acks_seen + 1;
        wait_count("store_complete", acks_seen, target);
        #1;
        cif.creq   = 1'b0;
        cif.cwrite = 1'b0;
    endtask

    initial begin
        int g0;
        int d0;
        cif.creq = 1'b0; cif.caddr = '0; cif.cwrite = 1'b0; cif.cin = '0; cif.ctype = '0;
        mif.mem_gnt = 1'b0; mif.mem_rvalid = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        // 1-cycle memory: words at cycles 3..6, addresses 0x1230..0x123C
        refill(32'h0000_1234, 32'h0000_1230, 0, 1, 1'b1);
        // slow grants and slow returns
        refill(32'h0000_1A50, 32'h0000_1A50, 3, 5, 1'b0);

        store(32'h0000_0102, 32'h0000_00AB, CT_BYTE,    32'h0000_0100, 32'hABAB_ABAB, 4'b0100);
        store(32'h0000_0206, 32'h0000_1234, CT_HWORD_U, 32'h0000_0204, 32'h1234_1234, 4'b1100);
        store(32'h0000_030C, 32'hDEAD_BEEF, CT_WORD,    32'h0000_030C, 32'hDEAD_BEEF, 4'hF);
        store(32'h0000_0401, 32'h0000_0055, CT_BAD,     32'h0000_0400, 32'h0000_0000, 4'h0);

        // reset in the middle of a refill, after two grants
        gnt_stall = 0;
        rlat      = 1;
        exp_ra.push_back(32'h0000_2000);
        exp_ra.push_back(32'h0000_2004);
        @(posedge clk); #1;
        cif.caddr = 32'h0000_2000; cif.cwrite = 1'b0; cif.creq = 1'b1;
        g0 = rd_grants;
        wait_count("two_grants_before_reset", rd_grants, g0 + 2);
        #1 rst = 1'b1;
        #1 check_all_zero("mid_reset");
        repeat (2) @(posedge clk);
        #1;
        cif.creq = 1'b0;
        rst      = 1'b0;
        refill(32'h0000_3008, 32'h0000_3000, 0, 1, 1'b1);

        // abort after word1: the rest is drained with cwait low
        gnt_stall = 0;
        rlat      = 3;
        for (int i = 0; i < 4; i++) exp_ra.push_back(32'h0000_4000 + 32'(4 * i));
        for (int i = 0; i < 2; i++) exp_rd.push_back('{dat: mem_word(32'h0000_4000 + 32'(4 * i)), cyc: -1});
        @(posedge clk); #1;
        cif.caddr = 32'h0000_4000; cif.cwrite = 1'b0; cif.creq = 1'b1;
        d0 = dlv_seen;
        wait_count("two_words_before_abort", dlv_seen, d0 + 2);
        #1 cif.creq = 1'b0;
        repeat (6) @(posedge clk);
        chk("drained_reads", pend.size(), 32'd0);
        // stray return while idle must be ignored
        stray_req++;
        repeat (3) @(posedge clk);
        store(32'h0000_0503, 32'h0000_005A, CT_BYTE, 32'h0000_0500, 32'h5A5A_5A5A, 4'b1000);
        refill(32'h0000_5010, 32'h0000_5010, 0, 2, 1'b0);

        repeat (5) @(posedge clk);
        chk("refill_queue_empty", exp_rd.size(), 32'd0);
        chk("read_addr_queue_empty", exp_ra.size(), 32'd0);
        chk("write_queue_empty", exp_wr.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
